// File: rtl/cr_clic_pkg.sv
// Shared definitions for the CLIC interrupt arbiter: FSM encoding, width defaults
// and the flattened per-source level slice.
`ifndef CR_CLIC_IL_SLICE
`define CR_CLIC_IL_SLICE(vec, i, w) vec[(i)*(w) +: (w)]
`endif

package cr_clic_pkg;

  localparam int ID_W_DEF = 10;
  localparam int IL_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_CLAIM = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

endpackage

// File: rtl/cr_clic_arb_tree.sv
// Combinational max-(level, id) tree over all sources; zero latency, no backpressure.
// Ties on level resolve to the higher id.
module cr_clic_arb_tree import cr_clic_pkg::*; #(
  parameter int NUM_INT = 16,
  parameter int ID_W    = ID_W_DEF,
  parameter int IL_W    = IL_W_DEF
) (
  input  logic [NUM_INT-1:0]      elig,
  input  logic [NUM_INT*IL_W-1:0] il,
  input  logic [NUM_INT-1:0]      hv,
  output logic                    win_vld,
  output logic [ID_W-1:0]         win_id,
  output logic [IL_W-1:0]         win_il,
  output logic                    win_hv
);

  localparam int LEAVES = (NUM_INT <= 1) ? 1 : (1 << $clog2(NUM_INT));
  localparam int NODES  = 2 * LEAVES - 1;

  logic            n_vld [NODES];
  logic [ID_W-1:0] n_id  [NODES];
  logic [IL_W-1:0] n_il  [NODES];
  logic            n_hv  [NODES];

  always_comb begin
    for (int n = 0; n < NODES; n++) begin
      n_vld[n] = 1'b0;
      n_id[n]  = '0;
      n_il[n]  = '0;
      n_hv[n]  = 1'b0;
    end
    for (int i = 0; i < NUM_INT; i++) begin
      n_vld[LEAVES-1+i] = elig[i];
      n_id[LEAVES-1+i]  = ID_W'(i);
      n_il[LEAVES-1+i]  = `CR_CLIC_IL_SLICE(il, i, IL_W);
      n_hv[LEAVES-1+i]  = hv[i];
    end
    // Right child always spans higher ids, so >= gives the higher-id tie break.
    for (int k = LEAVES - 2; k >= 0; k--) begin
      if (n_vld[2*k+2] && (!n_vld[2*k+1] || n_il[2*k+2] >= n_il[2*k+1])) begin
        n_vld[k] = 1'b1;
        n_id[k]  = n_id[2*k+2];
        n_il[k]  = n_il[2*k+2];
        n_hv[k]  = n_hv[2*k+2];
      end else begin
        n_vld[k] = n_vld[2*k+1];
        n_id[k]  = n_id[2*k+1];
        n_il[k]  = n_il[2*k+1];
        n_hv[k]  = n_hv[2*k+1];
      end
    end
  end

  assign win_vld = n_vld[0];
  assign win_id  = n_id[0];
  assign win_il  = n_il[0];
  assign win_hv  = n_hv[0];

endmodule

// File: rtl/cr_clic_int_arb.sv
// CLIC interrupt capture, arbitration and hold-until-ack presentation to the core.
// Edge to request is 3 cycles; the presented interrupt stays stable until ack or withdraw.
module cr_clic_int_arb import cr_clic_pkg::*; #(
  parameter int NUM_INT = 16,
  parameter int ID_W    = ID_W_DEF,
  parameter int IL_W    = IL_W_DEF
) (
  input  logic                    forever_cpuclk,
  input  logic                    cpurst_b,
  input  logic [NUM_INT-1:0]      pad_clic_int_req,
  input  logic [NUM_INT-1:0]      clic_int_trig,
  input  logic [NUM_INT-1:0]      clic_int_ie,
  input  logic [NUM_INT*IL_W-1:0] clic_int_il,
  input  logic [NUM_INT-1:0]      clic_int_hv,
  input  logic [IL_W-1:0]         cp0_iu_il,
  input  logic                    cp0_iu_mie_for_int,
  input  logic                    iu_cp0_int_vld,
  input  logic                    cpu_clic_int_exit,
  output logic                    clic_cpu_int_req,
  output logic [ID_W-1:0]         clic_cpu_int_id,
  output logic [IL_W-1:0]         clic_cpu_int_il,
  output logic                    clic_cpu_int_hv,
  output logic                    clic_pend_vld,
  output logic [ID_W-1:0]         clic_pend_id,
  output logic [IL_W-1:0]         clic_pend_il
);

  state_t              state;
  logic [NUM_INT-1:0]  req_d;
  logic [NUM_INT-1:0]  pend;
  logic [NUM_INT-1:0]  pend_nxt;
  logic [NUM_INT-1:0]  elig;
  logic [NUM_INT-1:0]  sel;
  logic                claim;
  logic                src_live;
  logic                withdraw;

  logic                arb_vld;
  logic [ID_W-1:0]     arb_id;
  logic [IL_W-1:0]     arb_il;
  logic                arb_hv;

  logic                win_vld;
  logic [ID_W-1:0]     win_id;
  logic [IL_W-1:0]     win_il;
  logic                win_hv;

  // Clearing on the ack edge makes the pending bit read 0 during the CLAIM cycle.
  assign claim = (state == ST_REQ) && iu_cp0_int_vld;

  always_comb begin
    elig     = '0;
    sel      = '0;
    pend_nxt = '0;
    for (int i = 0; i < NUM_INT; i++) begin
      elig[i] = pend[i] & clic_int_ie[i] & (|`CR_CLIC_IL_SLICE(clic_int_il, i, IL_W));
      sel[i]  = (clic_cpu_int_id == ID_W'(i));
      if (clic_int_trig[i]) begin
        pend_nxt[i] = (pad_clic_int_req[i] & ~req_d[i]) | (pend[i] & ~(sel[i] & claim));
      end else begin
        pend_nxt[i] = pad_clic_int_req[i];
      end
    end
  end

  assign src_live = |(sel & pend & clic_int_ie);
  assign withdraw = !src_live || !cp0_iu_mie_for_int || (cp0_iu_il >= clic_cpu_int_il);

  cr_clic_arb_tree #(
    .NUM_INT (NUM_INT),
    .ID_W    (ID_W),
    .IL_W    (IL_W)
  ) u_tree (
    .elig    (elig),
    .il      (clic_int_il),
    .hv      (clic_int_hv),
    .win_vld (win_vld),
    .win_id  (win_id),
    .win_il  (win_il),
    .win_hv  (win_hv)
  );

  assign clic_pend_vld    = arb_vld && (arb_il > cp0_iu_il);
  assign clic_pend_id     = arb_id;
  assign clic_pend_il     = arb_il;
  assign clic_cpu_int_req = (state == ST_REQ);

  always_ff @(posedge forever_cpuclk) begin
    if (!cpurst_b) begin
      state           <= ST_IDLE;
      req_d           <= '0;
      pend            <= '0;
      arb_vld         <= 1'b0;
      arb_id          <= '0;
      arb_il          <= '0;
      arb_hv          <= 1'b0;
      clic_cpu_int_id <= '0;
      clic_cpu_int_il <= '0;
      clic_cpu_int_hv <= 1'b0;
    end else begin
      req_d   <= pad_clic_int_req;
      pend    <= pend_nxt;
      arb_vld <= win_vld;
      arb_id  <= win_id;
      arb_il  <= win_il;
      arb_hv  <= win_hv;
      case (state)
        ST_IDLE: begin
          if (cpu_clic_int_exit) begin
            state <= ST_HOLD;
          end else if (clic_pend_vld && cp0_iu_mie_for_int) begin
            state           <= ST_REQ;
            clic_cpu_int_id <= arb_id;
            clic_cpu_int_il <= arb_il;
            clic_cpu_int_hv <= arb_hv;
          end
        end
        ST_REQ: begin
          if (iu_cp0_int_vld) begin
            state <= ST_CLAIM;
          end else if (withdraw) begin
            state <= ST_IDLE;
          end
        end
        ST_CLAIM: state <= ST_HOLD;
        ST_HOLD:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cr_clic_int_arb.sv
// Directed bench for cr_clic_int_arb with a scoreboard of expected presentations.
module tb_cr_clic_int_arb;
  import cr_clic_pkg::*;

  localparam int N   = 16;
  localparam int IDW = 10;
  localparam int ILW = 8;

  logic             forever_cpuclk = 1'b0;
  logic             cpurst_b;
  logic [N-1:0]     pad_clic_int_req;
  logic [N-1:0]     clic_int_trig;
  logic [N-1:0]     clic_int_ie;
  logic [N*ILW-1:0] clic_int_il;
  logic [N-1:0]     clic_int_hv;
  logic [ILW-1:0]   cp0_iu_il;
  logic             cp0_iu_mie_for_int;
  logic             iu_cp0_int_vld;
  logic             cpu_clic_int_exit;
  logic             clic_cpu_int_req;
  logic [IDW-1:0]   clic_cpu_int_id;
  logic [ILW-1:0]   clic_cpu_int_il;
  logic             clic_cpu_int_hv;
  logic             clic_pend_vld;
  logic [IDW-1:0]   clic_pend_id;
  logic [ILW-1:0]   clic_pend_il;

  always #5 forever_cpuclk = ~forever_cpuclk;

  cr_clic_int_arb #(.NUM_INT(N), .ID_W(IDW), .IL_W(ILW)) dut (
    .forever_cpuclk     (forever_cpuclk),
    .cpurst_b           (cpurst_b),
    .pad_clic_int_req   (pad_clic_int_req),
    .clic_int_trig      (clic_int_trig),
    .clic_int_ie        (clic_int_ie),
    .clic_int_il        (clic_int_il),
    .clic_int_hv        (clic_int_hv),
    .cp0_iu_il          (cp0_iu_il),
    .cp0_iu_mie_for_int (cp0_iu_mie_for_int),
    .iu_cp0_int_vld     (iu_cp0_int_vld),
    .cpu_clic_int_exit  (cpu_clic_int_exit),
    .clic_cpu_int_req   (clic_cpu_int_req),
    .clic_cpu_int_id    (clic_cpu_int_id),
    .clic_cpu_int_il    (clic_cpu_int_il),
    .clic_cpu_int_hv    (clic_cpu_int_hv),
    .clic_pend_vld      (clic_pend_vld),
    .clic_pend_id       (clic_pend_id),
    .clic_pend_il       (clic_pend_il)
  );

  typedef struct {
    int id;
    int il;
    int hv;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic tick();
    @(posedge forever_cpuclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int id, input int il, input int hv);
    exp_t e;
    e.id = id;
    e.il = il;
    e.hv = hv;
    sb.push_back(e);
  endtask

  // Edge pulse: request high across exactly one sampling edge.
  task automatic pulse(input int i);
    pad_clic_int_req[i] = 1'b1;
    tick();
    pad_clic_int_req[i] = 1'b0;
  endtask

  task automatic ack();
    iu_cp0_int_vld = 1'b1;
    tick();
    iu_cp0_int_vld = 1'b0;
  endtask

  // Waits (bounded) for the request, checks its latency and the scoreboard head.
  task automatic wait_req(input int exp_lat);
    int   lat = 0;
    exp_t e;
    do begin
      tick();
      lat++;
    end while (clic_cpu_int_req !== 1'b1 && lat < 20);
    chk("req_latency", lat, exp_lat);
    chk("sb_nonempty", sb.size() != 0, 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("req_id", clic_cpu_int_id, e.id);
      chk("req_il", clic_cpu_int_il, e.il);
      chk("req_hv", clic_cpu_int_hv, e.hv);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    cpurst_b           = 1'b0;
    pad_clic_int_req   = '0;
    clic_int_trig      = 16'hFFEF;
    clic_int_ie        = '1;
    clic_int_il        = '0;
    clic_int_hv        = 16'h00A0;
    cp0_iu_il          = '0;
    cp0_iu_mie_for_int = 1'b0;
    iu_cp0_int_vld     = 1'b0;
    cpu_clic_int_exit  = 1'b0;
    clic_int_il[2*ILW +: ILW] = 8'h10;
    clic_int_il[3*ILW +: ILW] = 8'h20;
    clic_int_il[4*ILW +: ILW] = 8'h50;
    clic_int_il[5*ILW +: ILW] = 8'h40;
    clic_int_il[7*ILW +: ILW] = 8'h20;
    clic_int_il[9*ILW +: ILW] = 8'h60;
    tick();
    tick();

    chk("rst_req", clic_cpu_int_req, 0);
    chk("rst_id", clic_cpu_int_id, 0);
    chk("rst_il", clic_cpu_int_il, 0);
    chk("rst_hv", clic_cpu_int_hv, 0);
    chk("rst_pvld", clic_pend_vld, 0);
    chk("rst_pid", clic_pend_id, 0);
    chk("rst_pil", clic_pend_il, 0);

    cpurst_b           = 1'b1;
    cp0_iu_mie_for_int = 1'b1;
    tick();

    // Single edge source
    push(5, 'h40, 1);
    pulse(5);
    wait_req(2);
    ack();
    chk("claim_pend5", dut.pend[5], 0);
    chk("claim_req", clic_cpu_int_req, 0);
    tick();
    chk("claim_snap", clic_pend_vld, 0);
    repeat (4) tick();
    chk("claim_norereq", clic_cpu_int_req, 0);

    // Tie on level resolves to higher id, then descending
    push(7, 'h20, 1);
    push(3, 'h20, 0);
    push(2, 'h10, 0);
    pad_clic_int_req[2] = 1'b1;
    pad_clic_int_req[3] = 1'b1;
    pad_clic_int_req[7] = 1'b1;
    tick();
    pad_clic_int_req = '0;
    wait_req(2);
    ack();
    wait_req(3);
    ack();
    wait_req(3);
    ack();
    repeat (5) tick();
    chk("tie_done_req", clic_cpu_int_req, 0);
    chk("tie_done_snap", clic_pend_vld, 0);

    // Level source withdraw without ack
    push(4, 'h50, 0);
    pad_clic_int_req[4] = 1'b1;
    wait_req(3);
    pad_clic_int_req[4] = 1'b0;
    tick();
    chk("wd_still_req", clic_cpu_int_req, 1);
    tick();
    chk("wd_drop", clic_cpu_int_req, 0);
    chk("wd_state", dut.state, ST_IDLE);

    // Ack and drop together: ack wins
    push(4, 'h50, 0);
    pad_clic_int_req[4] = 1'b1;
    wait_req(3);
    iu_cp0_int_vld      = 1'b1;
    pad_clic_int_req[4] = 1'b0;
    tick();
    iu_cp0_int_vld = 1'b0;
    chk("ackwd_claim", dut.state, ST_CLAIM);
    repeat (4) tick();
    chk("ackwd_idle_req", clic_cpu_int_req, 0);

    // Withdraw when MIL reaches the presented level, re-present just below it
    push(4, 'h50, 0);
    pad_clic_int_req[4] = 1'b1;
    wait_req(3);
    cp0_iu_il = 8'h50;
    tick();
    chk("mil_eq_wd", clic_cpu_int_req, 0);
    cp0_iu_il = 8'h4F;
    push(4, 'h50, 0);
    wait_req(1);
    pad_clic_int_req[4] = 1'b0;
    cp0_iu_il           = '0;
    tick();
    tick();
    chk("lvl_gone_req", clic_cpu_int_req, 0);

    // MIL gating of the snapshot and the request
    cp0_iu_il = 8'h80;
    pulse(5);
    tick();
    chk("milg_snap", clic_pend_vld, 0);
    chk("milg_pid", clic_pend_id, 5);
    tick();
    chk("milg_req", clic_cpu_int_req, 0);
    cp0_iu_il = 8'h30;
    #1;
    chk("milg_snap_open", clic_pend_vld, 1);
    push(5, 'h40, 1);
    wait_req(1);
    cp0_iu_il = 8'h40;
    ack();
    repeat (3) tick();
    cp0_iu_il = '0;
    tick();
    chk("milg_done_req", clic_cpu_int_req, 0);

    // MIE masks the request but not the snapshot
    cp0_iu_mie_for_int = 1'b0;
    pulse(9);
    tick();
    chk("mie_snap", clic_pend_vld, 1);
    chk("mie_pid", clic_pend_id, 9);
    chk("mie_pil", clic_pend_il, 'h60);
    tick();
    chk("mie_req", clic_cpu_int_req, 0);
    cp0_iu_mie_for_int = 1'b1;
    push(9, 'h60, 0);
    wait_req(1);
    ack();
    repeat (4) tick();

    // No preemption, then reset mid-REQ loses pending state
    push(5, 'h40, 1);
    pulse(5);
    wait_req(2);
    pulse(9);
    tick();
    chk("nopre_req", clic_cpu_int_req, 1);
    chk("nopre_id", clic_cpu_int_id, 5);
    cpurst_b = 1'b0;
    tick();
    cpurst_b = 1'b1;
    chk("rmid_req", clic_cpu_int_req, 0);
    chk("rmid_id", clic_cpu_int_id, 0);
    chk("rmid_il", clic_cpu_int_il, 0);
    chk("rmid_hv", clic_cpu_int_hv, 0);
    chk("rmid_snap", clic_pend_vld, 0);
    repeat (5) tick();
    chk("rmid_lost_req", clic_cpu_int_req, 0);
    chk("rmid_lost_snap", clic_pend_vld, 0);

    // Exit in IDLE holds off arbitration for one cycle
    cp0_iu_mie_for_int = 1'b0;
    pulse(3);
    tick();
    cp0_iu_mie_for_int = 1'b1;
    cpu_clic_int_exit  = 1'b1;
    push(3, 'h20, 0);
    tick();
    cpu_clic_int_exit = 1'b0;
    chk("exit_hold", clic_cpu_int_req, 0);
    wait_req(2);
    ack();
    repeat (4) tick();

    chk("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
